// File: rtl/xm23_pkg.sv
// Shared types and constants for the XM23 fetch stage.
package xm23_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        SLEEP = 2'd1
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } fetch_entry_t;

    localparam int unsigned IQ_DEPTH = 2;
    localparam logic [15:0] PC_STEP  = 16'd2;
    localparam logic [15:0] NOP_WORD = 16'h0000;

    // Instructions are halfword aligned; targets arriving with bit 0 set are truncated.
    function automatic logic [15:0] align_pc(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry prefetch FIFO holding {instruction, pc} pairs.
// Slot 0 is always the head; flush beats push and pop.
module fetch_queue
    import xm23_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slot [IQ_DEPTH];
    logic         do_pop;
    logic         do_push;
    logic [1:0]   wr_idx;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((32'(count) < IQ_DEPTH) || do_pop);
    assign wr_idx  = count - {1'b0, do_pop};

    // Shift on pop; a same-cycle push lands in the slot freed by the shift.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
            for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
                slot[i] <= '0;
            end
        end else begin
            if (do_pop) begin
                slot[0] <= slot[1];
            end
            if (do_push) begin
                slot[wr_idx[0]] <= din;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head = (count != 2'd0) ? slot[0] : '{instr: NOP_WORD, pc: NOP_WORD};

endmodule

// File: rtl/xm23_fetch_stage.sv
// XM23 instruction fetch stage: owns the fetch PC, issues halfword reads,
// buffers fetched words in a 2-entry queue, handles redirects and SLP sleep/wake.
module xm23_fetch_stage #(
    parameter logic [15:0]  RESET_PC = 16'h0000,
    parameter int unsigned  STALL_W  = 8,
    parameter int unsigned  IQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_in,
    input  logic               redirect_valid,
    input  logic [15:0]        redirect_pc,
    input  logic               sleep_req,
    input  logic [15:0]        sleep_pc,
    input  logic               wake,
    output logic               imem_req,
    output logic [15:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [15:0]        imem_rdata,
    output logic [15:0]        fetch_o,
    output logic [15:0]        fetch_pc_o,
    output logic               fetch_valid_o,
    output logic [1:0]         state_o
);
    import xm23_pkg::*;

    fetch_state_t state;
    fetch_state_t state_n;
    logic [15:0]  pc;
    logic [15:0]  pc_n;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t din;
    logic         accept;
    logic         consume;
    logic         flush;

    // Request never depends on stall_in, so a stalled pipeline keeps prefetching.
    assign imem_req = (state == FETCH) && !rst && !redirect_valid && !sleep_req
                      && (32'(count) < IQ_DEPTH);
    assign imem_addr     = pc;
    assign accept        = imem_req && imem_ack;
    assign fetch_valid_o = (count != 2'd0);
    assign consume       = fetch_valid_o && !(|stall_in);
    assign flush         = redirect_valid || sleep_req;
    assign din           = '{instr: imem_rdata, pc: pc};
    assign fetch_o       = head.instr;
    assign fetch_pc_o    = head.pc;
    assign state_o       = state;

    fetch_queue u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (consume),
        .flush (flush),
        .din   (din),
        .head  (head),
        .count (count)
    );

    // Next state and PC: redirect > sleep_req > wake > sequential advance.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        if (redirect_valid) begin
            state_n = FETCH;
            pc_n    = align_pc(redirect_pc);
        end else if (sleep_req) begin
            state_n = SLEEP;
            pc_n    = align_pc(sleep_pc);
        end else if (state == SLEEP) begin
            if (wake) begin
                state_n = FETCH;
            end
        end else if (accept) begin
            pc_n = pc + PC_STEP;
        end
    end

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

endmodule

// File: tb/tb_xm23_fetch_stage.sv
// Self-checking bench for xm23_fetch_stage: directed scenarios plus random
// traffic, all checked against a queue-based behavioural model.
module tb_xm23_fetch_stage;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } ent_t;

    logic        clk;
    logic        rst;
    logic [7:0]  stall_in;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        sleep_req;
    logic [15:0] sleep_pc;
    logic        wake;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] fetch_o;
    logic [15:0] fetch_pc_o;
    logic        fetch_valid_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pc;
    bit          m_sleep;
    bit          m_known;
    ent_t        m_q[$];

    xm23_fetch_stage #(
        .RESET_PC (16'h0000),
        .STALL_W  (8),
        .IQ_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .sleep_req      (sleep_req),
        .sleep_pc       (sleep_pc),
        .wake           (wake),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .fetch_o        (fetch_o),
        .fetch_pc_o     (fetch_pc_o),
        .fetch_valid_o  (fetch_valid_o),
        .state_o        (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input bit r, input logic [7:0] st, input bit rv, input logic [15:0] rpc,
                        input bit sr, input logic [15:0] spc, input bit wk, input bit ak);
        bit   exp_req;
        bit   exp_valid;
        ent_t e;
        rst            = r;
        stall_in       = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        sleep_req      = sr;
        sleep_pc       = spc;
        wake           = wk;
        imem_ack       = ak;
        imem_rdata     = m_pc ^ 16'hA5A5;
        #1;
        exp_req   = !m_sleep && !r && !rv && !sr && (m_q.size() < 2);
        exp_valid = (m_q.size() != 0);
        check("imem_req", {15'b0, imem_req}, {15'b0, exp_req});
        if (m_known) begin
            check("imem_addr", imem_addr, m_pc);
            check("fetch_valid", {15'b0, fetch_valid_o}, {15'b0, exp_valid});
            check("fetch_o", fetch_o, exp_valid ? m_q[0].instr : 16'h0000);
            check("fetch_pc", fetch_pc_o, exp_valid ? m_q[0].pc : 16'h0000);
            check("state", {14'b0, state_o}, m_sleep ? 16'd1 : 16'd0);
        end
        if (r) begin
            m_pc    = 16'h0000;
            m_sleep = 0;
            m_q.delete();
            m_known = 1;
        end else if (rv) begin
            m_q.delete();
            m_pc    = rpc & 16'hFFFE;
            m_sleep = 0;
        end else if (sr) begin
            m_q.delete();
            m_pc    = spc & 16'hFFFE;
            m_sleep = 1;
        end else if (m_sleep) begin
            if (wk) m_sleep = 0;
        end else begin
            if (exp_valid && st == 8'h00) void'(m_q.pop_front());
            if (exp_req && ak) begin
                e.instr = m_pc ^ 16'hA5A5;
                e.pc    = m_pc;
                m_q.push_back(e);
                m_pc = m_pc + 16'd2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n, input logic [7:0] st, input bit ak);
        for (int unsigned i = 0; i < n; i++) step(0, st, 0, 16'h0, 0, 16'h0, 0, ak);
    endtask

    task automatic do_reset(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1, 8'h00, 0, 16'h0, 0, 16'h0, 0, 1);
    endtask

    function automatic bit pct(input int unsigned p);
        return $urandom_range(0, 99) < p;
    endfunction

    initial begin
        m_pc    = 16'h0000;
        m_sleep = 0;
        m_known = 0;
        #1;

        // Streaming with constant ack.
        do_reset(2);
        idle(8, 8'h00, 1);

        // Stall fill from reset, then release.
        do_reset(1);
        idle(6, 8'h04, 1);
        idle(6, 8'h00, 1);

        // Redirect with a full queue and ack in the same cycle.
        idle(3, 8'h04, 1);
        step(0, 8'h04, 1, 16'h0101, 0, 16'h0, 0, 1);
        idle(4, 8'h00, 1);

        // Wait states: ack every third cycle.
        do_reset(1);
        for (int unsigned i = 0; i < 12; i++) idle(1, 8'h00, (i % 3) == 2);

        // Sleep, idle, wake.
        step(0, 8'h00, 0, 16'h0, 1, 16'h0040, 0, 1);
        idle(10, 8'h00, 1);
        step(0, 8'h00, 0, 16'h0, 0, 16'h0, 1, 1);
        idle(3, 8'h00, 1);

        // Redirect wins over sleep_req in the same cycle.
        step(0, 8'h00, 1, 16'h0200, 1, 16'h0040, 0, 1);
        idle(3, 8'h00, 1);

        // Sleep, reload while sleeping, then redirect out.
        step(0, 8'h00, 0, 16'h0, 1, 16'h0081, 0, 1);
        idle(2, 8'h00, 1);
        step(0, 8'h00, 0, 16'h0, 1, 16'h0300, 0, 1);
        step(0, 8'h00, 1, 16'h0500, 0, 16'h0, 0, 1);
        idle(2, 8'h00, 1);

        // PC wrap.
        step(0, 8'h00, 1, 16'hFFFC, 0, 16'h0, 0, 1);
        idle(5, 8'h00, 1);

        // Reset with a full queue and ack high.
        idle(4, 8'h20, 1);
        do_reset(1);
        idle(4, 8'h00, 1);

        // Random traffic.
        for (int unsigned i = 0; i < 3000; i++) begin
            logic [7:0] st;
            st = pct(35) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            step(pct(1), st, pct(4), 16'($urandom), pct(3), 16'($urandom),
                 pct(25), pct(60));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xm23_fetch_stage.md
Name: xm23_fetch_stage

Overview:
Instruction fetch stage for the XM23 pipeline. It sits directly upstream of pipeline_registers and drives its fetch_in. It owns the fetch PC and issues 16-bit instruction reads to instruction memory. Fetched words are buffered in a 2-entry prefetch queue so fetch continues during stalls. The stage also handles branch redirects and SLP sleep/wake.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset
STALL_W, 8, width of stall_in (any set bit = stall)
IQ_DEPTH, 2, prefetch queue entries (fixed at 2; other values unsupported)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
stall_in  in  STALL_W  stall vector, same encoding as pipeline_registers
redirect_valid  in  1  branch/jump/interrupt redirect pulse
redirect_pc  in  16  redirect target
sleep_req  in  1  SLP retired; enter sleep
sleep_pc  in  16  resume PC after SLP
wake  in  1  leave sleep (interrupt/event)
imem_req  out  1  read request
imem_addr  out  16  read address (= fetch PC)
imem_ack  in  1  request accepted; imem_rdata valid in the same cycle
imem_rdata  in  16  instruction word
fetch_o  out  16  queue head instruction, to pipeline_registers.fetch_in
fetch_pc_o  out  16  PC of fetch_o
fetch_valid_o  out  1  queue head valid
state_o  out  2  FSM state, debug

Behaviour:
- Reset (rst high at a posedge): PC=RESET_PC, queue count=0, state=FETCH. Any imem_ack in a reset cycle is ignored. imem_req=0 while rst=1. After reset, fetch_valid_o=0, and fetch_o and fetch_pc_o read 16'h0000.
- FSM states: FETCH(0), SLEEP(1).
  - FETCH -> SLEEP on sleep_req, unless redirect_valid is high in the same cycle.
  - SLEEP -> FETCH on wake or redirect_valid.
- imem_req = (state==FETCH) && !rst && !redirect_valid && !sleep_req && (count<2).
  - There is no combinational path from stall_in to imem_req.
- imem_addr = PC register. It is stable while a request is pending; the memory may insert any number of wait states.
- Accept = imem_req && imem_ack.
  - Push {imem_rdata, PC} into the queue.
  - PC <= PC+2, 16-bit wrap (16'hFFFE -> 16'h0000).
- Consume = fetch_valid_o && !(|stall_in). Consume pops the head. Push and pop may occur in the same cycle; count is unchanged.
- Latency: an accept in cycle t gives fetch_valid_o in cycle t+1 (if the queue was empty).
- Queue outputs: fetch_valid_o = (count!=0). When the queue is empty, fetch_o=16'h0000 and fetch_pc_o=16'h0000; pipeline_registers treats this as a bubble.
- Redirect in cycle t (highest priority, over stall, ack, sleep_req and wake):
  - imem_req=0 in cycle t; no push.
  - At t+1: count=0 and PC=redirect_pc with bit 0 cleared.
  - First request issued in cycle t+1.
- sleep_req in cycle t (no redirect): imem_req=0 in cycle t. At t+1: queue flushed, PC=sleep_pc with bit 0 cleared, state=SLEEP.
- SLEEP:
  - imem_req=0 and fetch_valid_o=0.
  - wake returns to FETCH next cycle with PC unchanged.
  - redirect_valid returns to FETCH with PC=redirect_pc.
  - sleep_req while in SLEEP reloads the PC.
- Queue full (count=2): no request, no push. If not stalled, the head pops and the next request is issued the following cycle.
- Stall with an empty queue: fetch continues; entries accumulate up to 2.

Decomposition:
- xm23_pkg holds:
  - fetch_state_t enum {FETCH, SLEEP}
  - fetch_entry_t struct {logic [15:0] instr; logic [15:0] pc;}
  - IQ_DEPTH=2, PC_STEP=2, NOP_WORD=16'h0000
- Sub-module fetch_queue: 2-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, din, head, count.
  - flush has priority over push and pop.

Test Plan:
- Stream: rst 2 cycles, imem_ack=1 constant, mem[a]=a^16'hA5A5 -> imem_addr 0,2,4,... on consecutive cycles; fetch_valid_o first high the cycle after the first accept, with fetch_pc_o=0 and fetch_o=16'hA5A5; then one new word per cycle.
- Stall fill: stall_in=8'h04 for 6 cycles from reset -> exactly 2 accepts, then imem_req=0; fetch_pc_o holds 0. On release -> pcs 0,2,4,6 delivered on consecutive cycles, no loss or duplication.
- Redirect with a full queue and imem_ack=1 in the same cycle, redirect_pc=16'h0101 -> that cycle has no push; next cycle count=0 and imem_addr=16'h0100; first valid output has fetch_pc_o=16'h0100.
- Wait states: imem_ack high every 3rd cycle -> imem_addr stable between acks; outputs pcs 0,2,4 only after their acks; fetch_valid_o gaps match.
- Sleep: sleep_req with sleep_pc=16'h0040, then 10 idle cycles -> imem_req=0, fetch_valid_o=0, state_o=1. Then wake -> next cycle imem_addr=16'h0040. Repeat with redirect_valid asserted in the same cycle as sleep_req (redirect_pc=16'h0200) -> state stays FETCH, next imem_addr=16'h0200.
- Wrap and mid-operation reset: redirect_pc=16'hFFFC -> addresses FFFC, FFFE, 0000. Assert rst while the queue is full -> next cycle fetch_valid_o=0 and imem_addr=RESET_PC; an ack during the rst cycle is not pushed.
